mem_rd_arbiter: RTL and testbench

- Shares the single AXI read-address/read-data port between the PageRank read requesters: vertex stream (0), in-edge stream (1), random PR reads (2).
- Round-robin arbitration with a per-requester outstanding-transaction limit.
- Requester index is stamped on ARID; R beats are steered back by RID.
- Replaces the ad-hoc pr_state read sequencing; requesters issue reads independently.

---
 rtl/mem_rd_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one AXI read-address / read-data port between the
// PageRank read requesters (0 = vertex stream, 1 = in-edge stream,
// 2 = random PR reads).
//   - Round-robin grant into a single registered AR slot, with a limit on
//     outstanding transactions per requester.
//   - ARID carries the requester index; R beats are steered back by RID.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/addr/len       per-requester read requests (sliced buses)
//   req_ready                one-cycle pulse when request i is latched
//   ar*_m                    AXI AR channel (master side)
//   r*_m                     AXI R channel (master side)
//   resp_valid/ready/data/last  per-requester response path
//   rid_err                  sticky flag: beat seen with an out-of-range RID
//   outstanding              per-requester outstanding count, 4 bits each
// Optional: define MEM_RD_ARB_STATS_EN to add stat_sel / stat_grants /
// stat_stall (per-requester AR handshake count and AR stall cycle count).
module mem_rd_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 512
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MEM_RD_ARB_STATS_EN
    input  logic [2:0]          stat_sel,
    output logic [31:0]         stat_grants,
    output logic [31:0]         stat_stall,
`endif
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*8-1:0]      req_len,
    output logic [N_REQ-1:0]        req_ready,
    output logic [15:0]             arid_m,
    output logic [ADDR_W-1:0]       araddr_m,
    output logic [7:0]              arlen_m,
    output logic [2:0]              arsize_m,
    output logic                    arvalid_m,
    input  logic                    arready_m,
    input  logic [15:0]             rid_m,
    input  logic [DATA_W-1:0]       rdata_m,
    input  logic                    rlast_m,
    input  logic                    rvalid_m,
    output logic                    rready_m,
    output logic [N_REQ-1:0]        resp_valid,
    input  logic [N_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_last,
    output logic                    rid_err,
    output logic [N_REQ*4-1:0]      outstanding
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 4;

    logic [PTR_W-1:0]  r_ptr;
    logic              r_arvalid;
    logic [PTR_W-1:0]  r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [N_REQ-1:0]  r_req_ready;
    logic              r_rid_err;
    logic [CNT_W-1:0]  r_cnt [N_REQ];

    logic              w_ar_hs;
    logic              w_slot_free;
    logic              w_rid_bad;
    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_inc;
    logic [N_REQ-1:0]  w_dec;
    logic              w_grant_vld;
    logic [PTR_W-1:0]  w_grant_idx;
    logic [PTR_W-1:0]  w_cand;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_len;

    assign w_ar_hs     = r_arvalid && arready_m;
    assign w_slot_free = !r_arvalid || arready_m;
    assign w_rid_bad   = rid_m >= 16'(N_REQ);

    // Eligibility counts the AR held in the slot as already reserved.
    always_comb begin
        w_elig = '0;
        w_inc  = '0;
        w_dec  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_valid[i] &&
                        ((5'(r_cnt[i]) + 5'(r_arvalid && (r_arid == PTR_W'(i))))
                         < 5'(MAX_OUT));
            w_inc[i]  = w_ar_hs && (r_arid == PTR_W'(i));
            w_dec[i]  = rvalid_m && rready_m && rlast_m && (rid_m == 16'(i));
        end
    end

    // Round-robin search starting at the pointer.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = PTR_W'((32'(r_ptr) + k) % N_REQ);
            if (!w_grant_vld && w_elig[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_len  = req_len[i*8 +: 8];
            end
        end
    end

    // AR slot, pointer and sticky RID error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_arvalid   <= 1'b0;
            r_arid      <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_req_ready <= '0;
            r_rid_err   <= 1'b0;
        end else begin
            r_req_ready <= '0;
            if (w_slot_free) begin
                if (w_grant_vld) begin
                    r_arvalid                <= 1'b1;
                    r_arid                   <= w_grant_idx;
                    r_araddr                 <= w_sel_addr;
                    r_arlen                  <= w_sel_len;
                    r_req_ready[w_grant_idx] <= 1'b1;
                    r_ptr <= PTR_W'((32'(w_grant_idx) + 32'd1) % N_REQ);
                end else begin
                    r_arvalid <= 1'b0;
                end
            end
            if (rvalid_m && w_rid_bad) begin
                r_rid_err <= 1'b1;
            end
        end
    end

    // Outstanding counters; a late rlast after reset must not wrap below 0.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
        end
    end

    // R steering by RID; unknown IDs are drained and dropped.
    always_comb begin
        resp_valid = '0;
        rready_m   = 1'b1;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rid_m == 16'(i)) begin
                resp_valid[i] = rvalid_m;
                rready_m      = resp_ready[i];
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            outstanding[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign arvalid_m = r_arvalid;
    assign arid_m    = 16'(r_arid);
    assign araddr_m  = r_araddr;
    assign arlen_m   = r_arlen;
    assign arsize_m  = 3'b110;
    assign req_ready = r_req_ready;
    assign rid_err   = r_rid_err;
    assign resp_data = rdata_m;
    assign resp_last = rlast_m;

`ifdef MEM_RD_ARB_STATS_EN
    logic [31:0] r_stat_grants [N_REQ];
    logic [31:0] r_stat_stall;

    // Saturating handshake and stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_stall <= '0;
        end else if (r_arvalid && !arready_m && (r_stat_stall != '1)) begin
            r_stat_stall <= r_stat_stall + 32'd1;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rst) begin
                r_stat_grants[i] <= '0;
            end else if (w_inc[i] && (r_stat_grants[i] != '1)) begin
                r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_grants = r_stat_grants[i];
            end
        end
    end

    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction-level
// reference model.
module tb_mem_rd_arbiter;

    localparam int N  = 3;
    localparam int MO = 4;
    localparam int AW = 64;
    localparam int DW = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*8-1:0]    req_len;
    logic [N-1:0]      req_ready;
    logic [15:0]       arid_m;
    logic [AW-1:0]     araddr_m;
    logic [7:0]        arlen_m;
    logic [2:0]        arsize_m;
    logic              arvalid_m;
    logic              arready_m;
    logic [15:0]       rid_m;
    logic [DW-1:0]     rdata_m;
    logic              rlast_m;
    logic              rvalid_m;
    logic              rready_m;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [DW-1:0]     resp_data;
    logic              resp_last;
    logic              rid_err;
    logic [N*4-1:0]    outstanding;
`ifdef MEM_RD_ARB_STATS_EN
    logic [2:0]        stat_sel;
    logic [31:0]       stat_grants;
    logic [31:0]       stat_stall;
`endif

    always #5 clk = ~clk;

    mem_rd_arbiter #(.N_REQ(N), .MAX_OUT(MO), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
`ifdef MEM_RD_ARB_STATS_EN
        .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_stall(stat_stall),
`endif
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .arid_m(arid_m), .araddr_m(araddr_m),
        .arlen_m(arlen_m), .arsize_m(arsize_m), .arvalid_m(arvalid_m),
        .arready_m(arready_m), .rid_m(rid_m), .rdata_m(rdata_m),
        .rlast_m(rlast_m), .rvalid_m(rvalid_m), .rready_m(rready_m),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .rid_err(rid_err), .outstanding(outstanding)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic [2:0] rv, input logic ard,
                          input logic rval, input logic [15:0] rid,
                          input logic rl, input logic [2:0] rrdy);
        rst        = r;
        req_valid  = rv;
        arready_m  = ard;
        rvalid_m   = rval;
        rid_m      = rid;
        rlast_m    = rl;
        resp_ready = rrdy;
    endtask

    task automatic default_payload();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 64'h1000 * 64'(i + 1);
            req_len[i*8 +: 8]    = 8'(i + 3);
        end
    endtask

    function automatic logic [63:0] addr_of(input logic [15:0] id);
        return 64'h1000 * (64'(id) + 64'd1);
    endfunction

    typedef struct {
        logic        rst;
        logic [2:0]  rv;
        logic        ard;
        logic        rval;
        logic [15:0] rid;
        logic        rlast;
        logic [2:0]  rrdy;
        logic        arv;
        logic [15:0] arid;
        logic [2:0]  rrq;
        logic [11:0] cnt;
        logic [2:0]  rsv;
        logic        rrm;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    // Reference model state (transaction level).
    bit          m_arv;
    int          m_arid;
    logic [63:0] m_araddr;
    logic [7:0]  m_arlen;
    int          m_cnt [N];
    int          m_ptr;
    bit          m_err;
    logic [2:0]  m_rrq;
    logic [2:0]  e_rsv;
    logic        e_rrm;

    task automatic model_comb();
        e_rsv = '0;
        e_rrm = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (int'(rid_m) == i) begin
                e_rsv[i] = rvalid_m;
                e_rrm    = resp_ready[i];
            end
        end
    endtask

    task automatic model_step();
        int  nc [N];
        bit  hs;
        bit  found;
        int  g;
        if (rst) begin
            m_arv = 0; m_arid = 0; m_araddr = '0; m_arlen = '0;
            m_ptr = 0; m_err = 0; m_rrq = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            return;
        end
        hs = m_arv && arready_m;
        for (int i = 0; i < N; i++) begin
            nc[i] = m_cnt[i] + ((hs && m_arid == i) ? 1 : 0)
                    - ((rvalid_m && e_rrm && rlast_m && int'(rid_m) == i) ? 1 : 0);
            if (nc[i] < 0) nc[i] = 0;
        end
        m_rrq = '0;
        if (!m_arv || arready_m) begin
            found = 0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!found && req_valid[i] &&
                    (m_cnt[i] + ((m_arv && m_arid == i) ? 1 : 0)) < MO) begin
                    found = 1;
                    g     = i;
                end
            end
            if (found) begin
                m_arv    = 1;
                m_arid   = g;
                m_araddr = req_addr[g*AW +: AW];
                m_arlen  = req_len[g*8 +: 8];
                m_rrq[g] = 1'b1;
                m_ptr    = (g + 1) % N;
            end else begin
                m_arv = 0;
            end
        end
        for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
        if (rvalid_m && int'(rid_m) >= N) m_err = 1;
    endtask

    task automatic model_check();
        logic [11:0] ec;
        for (int i = 0; i < N; i++) ec[i*4 +: 4] = 4'(m_cnt[i]);
        chk("rnd_arvalid", 512'(arvalid_m), 512'(m_arv));
        chk("rnd_arid", 512'(arid_m), 512'(m_arid));
        chk("rnd_araddr", 512'(araddr_m), 512'(m_araddr));
        chk("rnd_arlen", 512'(arlen_m), 512'(m_arlen));
        chk("rnd_arsize", 512'(arsize_m), 512'(3'b110));
        chk("rnd_req_ready", 512'(req_ready), 512'(m_rrq));
        chk("rnd_outstanding", 512'(outstanding), 512'(ec));
        chk("rnd_rid_err", 512'(rid_err), 512'(m_err));
    endtask

    initial begin
        rdata_m  = '0;
        req_addr = '0;
        req_len  = '0;
`ifdef MEM_RD_ARB_STATS_EN
        stat_sel = 3'd0;
`endif
        default_payload();

        // Directed vector table
        tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000, 1'b0, 16'd0, 3'b000, 12'h000, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'b001, 1'b1, 1'b0, 16'd0, 1'b0, 3'b000, 1'b1, 16'd0, 3'b001, 12'h000, 3'b000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'b100, 1'b1, 1'b0, 16'd0, 1'b0, 3'b000, 1'b1, 16'd2, 3'b100, 12'h001, 3'b000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'b000, 1'b1, 1'b1, 16'd2, 1'b1, 3'b000, 1'b0, 16'd2, 3'b000, 12'h101, 3'b100, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'b000, 1'b0, 1'b1, 16'd2, 1'b1, 3'b100, 1'b0, 16'd2, 3'b000, 12'h001, 3'b100, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'b000, 1'b0, 1'b1, 16'd5, 1'b1, 3'b000, 1'b0, 16'd2, 3'b000, 12'h001, 3'b000, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 3'b000, 1'b0, 1'b0, 16'd0, 1'b0, 3'b001, 1'b0, 16'd2, 3'b000, 12'h001, 3'b000, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 3'b000, 1'b0, 1'b1, 16'd0, 1'b1, 3'b001, 1'b0, 16'd2, 3'b000, 12'h000, 3'b001, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 3'b000, 1'b0, 1'b1, 16'd1, 1'b0, 3'b010, 1'b0, 16'd2, 3'b000, 12'h000, 3'b010, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 1'b1, 16'd1, 1'b1, 3'b010, 1'b0, 16'd2, 3'b000, 12'h000, 3'b010, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 3'b010, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000, 1'b1, 16'd1, 3'b010, 12'h000, 3'b000, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 3'b010, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000, 1'b0, 16'd0, 3'b000, 12'h000, 3'b000, 1'b0, 1'b0};

        for (int v = 0; v < 12; v++) begin
            set_in(tbl[v].rst, tbl[v].rv, tbl[v].ard, tbl[v].rval, tbl[v].rid,
                   tbl[v].rlast, tbl[v].rrdy);
            #1;
            chk($sformatf("v%0d_resp_valid", v), 512'(resp_valid), 512'(tbl[v].rsv));
            chk($sformatf("v%0d_rready", v), 512'(rready_m), 512'(tbl[v].rrm));
            tick();
            chk($sformatf("v%0d_arvalid", v), 512'(arvalid_m), 512'(tbl[v].arv));
            chk($sformatf("v%0d_arid", v), 512'(arid_m), 512'(tbl[v].arid));
            chk($sformatf("v%0d_req_ready", v), 512'(req_ready), 512'(tbl[v].rrq));
            chk($sformatf("v%0d_outstanding", v), 512'(outstanding), 512'(tbl[v].cnt));
            chk($sformatf("v%0d_rid_err", v), 512'(rid_err), 512'(tbl[v].err));
            if (tbl[v].arv)
                chk($sformatf("v%0d_araddr", v), 512'(araddr_m), 512'(addr_of(tbl[v].arid)));
        end

        // Fairness: continuous requests, no responses
        set_in(1'b1, 3'b000, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000);
        tick();
        set_in(1'b0, 3'b111, 1'b1, 1'b0, 16'd0, 1'b0, 3'b000);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk($sformatf("fair%0d_arvalid", c), 512'(arvalid_m), 512'(1'b1));
            chk($sformatf("fair%0d_arid", c), 512'(arid_m), 512'(c % 3));
            chk($sformatf("fair%0d_req_ready", c), 512'(req_ready), 512'(1 << (c % 3)));
        end
        tick();
        chk("fair_end_arvalid", 512'(arvalid_m), 512'(1'b0));
        chk("fair_end_outstanding", 512'(outstanding), 512'(12'h444));
        tick();
        chk("fair_idle_arvalid", 512'(arvalid_m), 512'(1'b0));
        chk("fair_idle_req_ready", 512'(req_ready), 512'(3'b000));

        // AR backpressure on a grant to requester 1
        set_in(1'b1, 3'b000, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000);
        tick();
        set_in(1'b0, 3'b010, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000);
        tick();
        chk("bp_grant_arid", 512'(arid_m), 512'(16'd1));
        chk("bp_grant_req_ready", 512'(req_ready), 512'(3'b010));
        req_valid = 3'b111;
        req_addr[1*AW +: AW] = 64'hdead_beef;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("bp%0d_arvalid", s), 512'(arvalid_m), 512'(1'b1));
            chk($sformatf("bp%0d_arid", s), 512'(arid_m), 512'(16'd1));
            chk($sformatf("bp%0d_araddr", s), 512'(araddr_m), 512'(64'h2000));
            chk($sformatf("bp%0d_req_ready", s), 512'(req_ready), 512'(3'b000));
        end
        arready_m = 1'b1;
        tick();
        chk("bp_release_outstanding", 512'(outstanding), 512'(12'h010));
        chk("bp_release_arid", 512'(arid_m), 512'(16'd2));
        chk("bp_release_req_ready", 512'(req_ready), 512'(3'b100));
        default_payload();

        // Same-cycle increment and decrement for requester 0
        set_in(1'b1, 3'b000, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000);
        tick();
        set_in(1'b0, 3'b001, 1'b1, 1'b0, 16'd0, 1'b0, 3'b000);
        tick();
        tick();
        tick();
        set_in(1'b0, 3'b000, 1'b0, 1'b0, 16'd0, 1'b0, 3'b000);
        tick();
        chk("incdec_pre_cnt", 512'(outstanding), 512'(12'h002));
        chk("incdec_pre_arvalid", 512'(arvalid_m), 512'(1'b1));
        set_in(1'b0, 3'b000, 1'b1, 1'b1, 16'd0, 1'b1, 3'b001);
        tick();
        chk("incdec_cnt", 512'(outstanding), 512'(12'h002));
        chk("incdec_arvalid", 512'(arvalid_m), 512'(1'b0));

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = (cyc == 0) || ($urandom_range(0, 299) == 0);
            req_valid  = 3'($urandom);
            arready_m  = ($urandom_range(0, 9) < 7);
            rvalid_m   = 1'($urandom);
            rlast_m    = 1'($urandom);
            resp_ready = 3'($urandom);
            rid_m      = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(3, 7))
                                                     : 16'($urandom_range(0, 2));
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW] = {$urandom, $urandom};
                req_len[i*8 +: 8]    = 8'($urandom);
            end
            for (int w = 0; w < DW / 32; w++) rdata_m[w*32 +: 32] = $urandom;
            #1;
            model_comb();
            chk("rnd_resp_valid", 512'(resp_valid), 512'(e_rsv));
            chk("rnd_rready", 512'(rready_m), 512'(e_rrm));
            chk("rnd_resp_data", resp_data, rdata_m);
            chk("rnd_resp_last", 512'(resp_last), 512'(rlast_m));
            model_step();
            tick();
            model_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
